// File: rtl/alu_mc_if.sv
// Handshaked operation/result bus for alu_mc: operands and opcode in, result and flags out.
interface alu_mc_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       ALUOP;
    logic [WIDTH-1:0] BusA;
    logic [WIDTH-1:0] BusB;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] RES;
    logic             Zero;
    logic             Neg;
    logic             Carry;
    logic             Ovf;

    modport master (
        output in_valid, ALUOP, BusA, BusB, out_ready,
        input  in_ready, out_valid, RES, Zero, Neg, Carry, Ovf
    );

    modport slave (
        input  in_valid, ALUOP, BusA, BusB, out_ready,
        output in_ready, out_valid, RES, Zero, Neg, Carry, Ovf
    );
endinterface

// File: rtl/alu_mc.sv
// Execute-stage ALU with registered result/flags and valid/ready handshake on both sides.
// Define ALU_MUL_EN to build the iterative shift-add multiply for opcode 1010.
module alu_mc #(
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic    clk,
    input  logic    reset,
    alu_mc_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;

    logic             in_ready;
    logic             accept;
    logic             is_mul;
    logic [WIDTH:0]   add_w;
    logic [WIDTH-1:0] sub_w;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_ovf;

`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1010;

    logic [WIDTH-1:0] mul_a_q, mul_a_d;
    logic [WIDTH-1:0] mul_b_q, mul_b_d;
    logic [WIDTH-1:0] mul_acc_q, mul_acc_d;
    logic [WIDTH-1:0] mul_sum;
    logic [SHW-1:0]   mul_cnt_q, mul_cnt_d;

    assign is_mul = (bus.ALUOP == OP_MUL);
`else
    assign is_mul = 1'b0;
`endif

    assign in_ready      = (state_q == IDLE) || ((state_q == HOLD) && bus.out_ready);
    assign accept        = bus.in_valid && in_ready;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.RES       = res_q;
    assign bus.Zero      = zero_q;
    assign bus.Neg       = neg_q;
    assign bus.Carry     = carry_q;
    assign bus.Ovf       = ovf_q;

    // Single-cycle operations, evaluated on the live operands at accept time.
    always_comb begin
        add_w     = {1'b0, bus.BusA} + {1'b0, bus.BusB};
        sub_w     = bus.BusA - bus.BusB;
        shamt     = bus.BusB[SHW-1:0];
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (bus.ALUOP)
            4'b0000: begin
                alu_res   = add_w[WIDTH-1:0];
                alu_carry = add_w[WIDTH];
                alu_ovf   = (bus.BusA[WIDTH-1] == bus.BusB[WIDTH-1]) &&
                            (add_w[WIDTH-1] != bus.BusA[WIDTH-1]);
            end
            4'b0001: begin
                alu_res   = sub_w;
                alu_carry = (bus.BusA >= bus.BusB);
                alu_ovf   = (bus.BusA[WIDTH-1] != bus.BusB[WIDTH-1]) &&
                            (sub_w[WIDTH-1] != bus.BusA[WIDTH-1]);
            end
            4'b0010: alu_res = bus.BusA | bus.BusB;
            4'b0011: alu_res = ~(bus.BusA | bus.BusB);
            4'b0100: alu_res = bus.BusA & bus.BusB;
            4'b0101: alu_res = WIDTH'($signed(bus.BusA) < $signed(bus.BusB));
            4'b0110: alu_res = bus.BusA << shamt;
            4'b0111: alu_res = bus.BusA >> shamt;
            4'b1000: alu_res = $signed(bus.BusA) >>> shamt;
            4'b1001: alu_res = bus.BusA ^ bus.BusB;
            default: alu_res = '0;
        endcase
    end

    // Next-state and result update.
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
`ifdef ALU_MUL_EN
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        mul_acc_d = mul_acc_q;
        mul_cnt_d = mul_cnt_q;
        mul_sum   = mul_acc_q + (mul_b_q[0] ? mul_a_q : '0);

        if (state_q == BUSY) begin
            mul_a_d   = mul_a_q << 1;
            mul_b_d   = mul_b_q >> 1;
            mul_acc_d = mul_sum;
            mul_cnt_d = mul_cnt_q + SHW'(1);
            if (mul_cnt_q == SHW'(WIDTH - 1)) begin
                state_d = HOLD;
                res_d   = mul_sum;
                carry_d = 1'b0;
                ovf_d   = 1'b0;
            end
        end
`endif
        if ((state_q == HOLD) && bus.out_ready) begin
            state_d = IDLE;
        end

        if (accept && is_mul) begin
            state_d = BUSY;
`ifdef ALU_MUL_EN
            mul_a_d   = bus.BusA;
            mul_b_d   = bus.BusB;
            mul_acc_d = '0;
            mul_cnt_d = '0;
`endif
        end else if (accept) begin
            state_d = HOLD;
            res_d   = alu_res;
            carry_d = alu_carry;
            ovf_d   = alu_ovf;
        end

        zero_d = (res_d == '0);
        neg_d  = res_d[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            res_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
        end
    end

`ifdef ALU_MUL_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            mul_acc_q <= '0;
            mul_cnt_q <= '0;
        end else begin
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
            mul_acc_q <= mul_acc_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end
`endif
endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc; multiply expectations follow ALU_MUL_EN.
module tb_alu_mc;
    localparam int unsigned W = 32;

    typedef struct packed {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [3:0]   zncv;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_mc_if #(.WIDTH(W)) bus ();

    alu_mc #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [W+4:0] obs;
    logic [W+4:0] exp_v;

    task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.in_valid = 1'b1;
        bus.ALUOP    = op;
        bus.BusA     = a;
        bus.BusB     = b;
    endtask

    task automatic sample();
        obs = {bus.out_valid, bus.RES, bus.Zero, bus.Neg, bus.Carry, bus.Ovf};
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.ALUOP     = 4'h0;
        bus.BusA      = '0;
        bus.BusB      = '0;
        reset         = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        sample();
        exp_v = {1'b0, 32'h0, 4'b1000};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", obs, exp_v);
        end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
    endtask

    // Back-to-back single-cycle ops with out_ready held high.
    task automatic test_ops();
        vec_t vecs[16];
        vecs = '{
            '{4'h0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1010},
            '{4'h0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0101},
            '{4'h1, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 4'b0100},
            '{4'h1, 32'h00000007, 32'h00000005, 32'h00000002, 4'b0010},
            '{4'h1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011},
            '{4'h5, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000},
            '{4'h5, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 4'b1000},
            '{4'h8, 32'h80000000, 32'h00000004, 32'hF8000000, 4'b0100},
            '{4'h7, 32'h80000000, 32'h00000004, 32'h08000000, 4'b0000},
            '{4'h6, 32'h00000001, 32'h00000021, 32'h00000002, 4'b0000},
            '{4'h2, 32'hF0F00000, 32'h00000F0F, 32'hF0F00F0F, 4'b0100},
            '{4'h3, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 4'b0100},
            '{4'h4, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 4'b0000},
            '{4'h9, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 4'b0000},
            '{4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b1000},
            '{4'h0, 32'h80000000, 32'h80000000, 32'h00000000, 4'b1011}
        };
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b);
            @(negedge clk);
            sample();
            exp_v = {1'b1, vecs[i].res, vecs[i].zncv};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL op_vec%0d: got %h expected %h", i, obs, exp_v);
            end
            n_checks++;
            if (bus.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL op_in_ready%0d: got %b expected 1", i, bus.in_ready);
            end
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_idle: got %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        drive(4'h0, 32'd1, 32'd2);
        @(negedge clk);
        drive(4'h2, 32'd4, 32'd8);
        for (int k = 0; k < 3; k++) begin
            sample();
            exp_v = {1'b1, 32'd3, 4'b0000};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got %h expected %h", k, obs, exp_v);
            end
            n_checks++;
            if (bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_in_ready%0d: got %b expected 0", k, bus.in_ready);
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_ready: got %b expected 1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        sample();
        exp_v = {1'b1, 32'd12, 4'b0000};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL bp_second_op: got %h expected %h", obs, exp_v);
        end
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: got %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_mul();
        logic [W-1:0] ma[2];
        logic [W-1:0] mb[2];
        logic [W-1:0] mr[2];
        int lat;
        ma = '{32'h00001234, 32'hFFFFFFFF};
        mb = '{32'h00000010, 32'hFFFFFFFF};
        mr = '{32'h00012340, 32'h00000001};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(4'hA, ma[i], mb[i]);
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.ALUOP    = 4'h0;
            bus.BusA     = 32'h5A5A5A5A;
            bus.BusB     = 32'h00000003;
`ifdef ALU_MUL_EN
            lat = 1;
            while (bus.out_valid !== 1'b1 && lat < 40) begin
                n_checks++;
                if (bus.in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL mul%0d_busy_ready cyc%0d: got %b expected 0", i, lat, bus.in_ready);
                end
                @(negedge clk);
                lat++;
            end
            n_checks++;
            if (lat != 33) begin
                n_fail++;
                $display("FAIL mul%0d_latency: got %0d expected 33", i, lat);
            end
            sample();
            exp_v = {1'b1, mr[i], 2'b00, 2'b00};
`else
            lat = 1;
            sample();
            exp_v = {1'b1, 32'h0, 4'b1000};
`endif
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL mul%0d_result lat%0d: got %h expected %h", i, lat, obs, exp_v);
            end
        end
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_drain: got %b expected 0", bus.out_valid);
        end
    endtask

    // Reset lands mid-multiply together with an offered ADD that must not be taken.
    task automatic test_reset_mid_mul();
        bus.out_ready = 1'b1;
        drive(4'hA, 32'h00001234, 32'h00000010);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        drive(4'h0, 32'd5, 32'd5);
        @(negedge clk);
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        sample();
        exp_v = {1'b0, 32'h0, 4'b1000};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL rst_mid_state: got %h expected %h", obs, exp_v);
        end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_in_ready: got %b expected 1", bus.in_ready);
        end
        drive(4'h0, 32'd2, 32'd2);
        @(negedge clk);
        bus.in_valid = 1'b0;
        sample();
        exp_v = {1'b1, 32'd4, 4'b0000};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL rst_post_add: got %h expected %h", obs, exp_v);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_ops();
        test_backpressure();
        test_mul();
        test_reset_mid_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Parametrised, handshaked successor to the single-cycle execute-stage ALU. It registers its result and flags, and adds shift, compare, XOR and an optional iterative multiply. Valid/ready on both sides lets the pipeline control logic stall it. It sits in the EX stage and drives the EX/MEM register input.

Parameters:
WIDTH, 32, datapath width in bits (power of two, ≥8)
SHW, $clog2(WIDTH), shift-amount width (derived; do not override)

Ports:
clk  in  1  clock, rising-edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  operation presented
in_ready  out  1  block can accept operation this cycle
ALUOP  in  4  operation code
BusA  in  WIDTH  operand A
BusB  in  WIDTH  operand B
out_valid  out  1  RES/flags valid
out_ready  in  1  consumer takes result this cycle
RES  out  WIDTH  registered result
Zero  out  1  RES == 0
Neg  out  1  RES[WIDTH-1]
Carry  out  1  carry flag
Ovf  out  1  signed overflow flag

Behaviour:
- One clock (clk); reset is synchronous and active-high (reset).
- Opcodes:
  - 0000 ADD, 0001 SUB (A-B), 0010 OR, 0011 NOR, 0100 AND
  - 0101 SLT (signed A<B → 1, else 0), 0110 SLL, 0111 SRL, 1000 SRA (amount = BusB[SHW-1:0]), 1001 XOR
  - 1010 MUL (low WIDTH bits of A*B)
  - 1011-1111: RES=0, all other flags 0, Zero=1
- Flags:
  - ADD: Carry = carry-out of the WIDTH-bit sum; Ovf = signed overflow.
  - SUB: Carry = 1 when A ≥ B unsigned (no borrow); Ovf = signed overflow.
  - All other ops: Carry=0, Ovf=0.
  - Zero and Neg are always derived from RES.
- Transfer rules: accept when in_valid && in_ready; output consumed when out_valid && out_ready.
- States:
  - IDLE: out_valid=0, in_ready=1.
  - BUSY: MUL iterating; in_ready=0, out_valid=0.
  - HOLD: out_valid=1; in_ready = out_ready.
- Transitions:
  - IDLE, accept non-MUL → HOLD next edge, result registered. Latency 1.
  - IDLE, accept MUL → BUSY; shift-add one bit/cycle, counter 0..WIDTH-1; after WIDTH cycles → HOLD. Latency WIDTH+1.
  - HOLD, out_ready=1, no accept → IDLE.
  - HOLD, out_ready=1, accept non-MUL → stay HOLD with new result. Throughput 1 op/cycle.
  - HOLD, out_ready=1, accept MUL → BUSY.
  - HOLD, out_ready=0 → hold RES/flags stable; in_ready=0.
- Operands are latched at accept; BusA/BusB/ALUOP changes while BUSY are ignored.
- in_valid while in_ready=0 is not an error; the operation waits.
- Reset, including mid-MUL: state→IDLE, MUL counter cleared, RES=0, Carry=Ovf=Neg=0, Zero=1, out_valid=0, in_ready=1 in the cycle after reset deasserts. Reset overrides any same-cycle accept.

Optional Feature:
ALU_MUL_EN.
- Defined: opcode 1010 runs the iterative multiply described above.
- Undefined: 1010 is treated as an unused opcode (RES=0, single cycle, Zero=1), BUSY is unreachable, and no multiplier or counter logic is synthesized.

Test Plan:
- ADD A=32'hFFFFFFFF, B=1, out_ready=1 → next cycle out_valid=1, RES=0, Zero=1, Carry=1, Ovf=0.
- ADD A=32'h7FFFFFFF, B=1 → RES=32'h80000000, Ovf=1, Neg=1, Carry=0. SUB 5-7 → RES=32'hFFFFFFFE, Neg=1, Carry=0. SLT A=-1, B=1 → RES=1.
- SRA A=32'h80000000, B=4 → RES=32'hF8000000; SLL A=1, B=33 → RES=2 (only low 5 bits used).
- Backpressure: ADD 1+2 accepted, out_ready=0 for 3 cycles → RES=3 held, in_ready=0, a second OR waits; raise out_ready → 3 consumed, then OR result on the following cycle.
- ALU_MUL_EN defined: MUL 32'h1234 × 32'h10 → out_valid exactly 33 cycles after accept, RES=32'h12340, in_ready=0 throughout. Undefined: same stimulus → RES=0 after 1 cycle.
- Assert reset 10 cycles into a MUL → the cycle after deassertion shows out_valid=0, in_ready=1, RES=0, Zero=1; a following ADD 2+2 returns 4 with latency 1.
